// File: rtl/uart_rx_sampler_if.sv
// Receive-side strobe bundle of uart_rx_sampler: byte strobe, byte, and the two error strobes.
// The receiver drives it through the master modport and the FIFO/consumer reads it through the slave modport.
interface uart_rx_sampler_if;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_frameError;
    logic       o_parityError;

    modport master (
        output o_valid,
        output o_data,
        output o_frameError,
        output o_parityError
    );

    modport slave (
        input o_valid,
        input o_data,
        input o_frameError,
        input o_parityError
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 16x oversampling 8N1 UART receiver with 2-flop sync, 3-sample majority vote and framing-error strobe.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames (sense from PARITY_ODD) with an o_parityError strobe.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE),
    parameter int PARITY_ODD = 0
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_serialIn,
    uart_rx_sampler_if.master rx_out
);

    if (OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_sampler: OVERSAMPLE must be 16");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_sampler: DIV must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_rx_sampler: PARITY_ODD must be 0 or 1");
    end

    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rx_prev_q, rx_prev_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             s7_q, s7_d;
    logic             s8_q, s8_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic rx;
    logic tick;
    logic vote_tick;
    logic boundary;
    logic vote;

    assign rx        = sync2_q;
    assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
    assign vote_tick = tick && (smp_cnt_q == 4'd9);
    assign boundary  = tick && (smp_cnt_q == 4'd15);
    // Samples 7 and 8 are held in flops; sample 9 is the live line at the deciding tick.
    assign vote      = (s7_q & s8_q) | (s7_q & rx) | (s8_q & rx);

    always_comb begin
        sync1_d     = i_serialIn;
        sync2_d     = sync1_q;
        rx_prev_d   = rx;
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        smp_cnt_d   = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        s7_d        = (tick && smp_cnt_q == 4'd7) ? rx : s7_q;
        s8_d        = (tick && smp_cnt_q == 4'd8) ? rx : s8_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Restart the sample grid on the start edge so ticks line up with the bit cells.
                if (rx_prev_q && !rx) begin
                    state_d   = ST_START;
                    div_cnt_d = '0;
                    smp_cnt_d = '0;
                end
            end
            ST_START: begin
                if (vote_tick && vote) begin
                    state_d = ST_IDLE;
                end else if (boundary) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (vote_tick) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (boundary) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_tick) begin
                    par_bit_d = vote;
                end
                if (boundary) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at the stop vote so a following start edge is never missed.
                if (vote_tick) begin
                    if (vote) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^shift_q) ^ par_bit_q ^ (PARITY_ODD != 0);
`endif
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_out.o_valid      = valid_q;
    assign rx_out.o_data       = data_q;
    assign rx_out.o_frameError = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign rx_out.o_parityError = parity_err_q;
`else
    assign rx_out.o_parityError = 1'b0;
`endif

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling UART receiver for the UART expansion card. Converts the asynchronous `i_serialIn` line (8N1, LSB first) into byte-wide words on the card's 100 MHz clock domain. Each received byte is presented as a single-cycle `o_valid` pulse, which directly drives the write side of the receive FIFO. Adds metastability synchronisation, start-bit glitch rejection, 3-sample majority voting and framing-error reporting.

## Interface
- `CLK_FREQ`, 100000000, input clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `OVERSAMPLE`, 16, samples per bit period; fixed value, must be 16
- `DIV`, round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 54, clocks per sample tick; elaboration error if < 2
- `PARITY_ODD`, 0, parity sense (0 = even, 1 = odd); used only with `UART_RX_PARITY_EN`
- `i_clk` in 1: single clock (`i_clk100`). One clock; reset is synchronous and active-low.
- `i_resetn` in 1: synchronous, active-low reset
- `i_serialIn` in 1: asynchronous serial line, idle high
- `o_valid` out 1: one-cycle strobe, `o_data` holds a good byte
- `o_data` out 8: received byte; held until the next `o_valid`
- `o_frameError` out 1: one-cycle strobe, stop bit sampled low
- `o_parityError` out 1: one-cycle strobe, parity mismatch

## Operation
- **Synchroniser:** 2 flops, both reset to 1. All logic uses the second-stage output `rx`.
- **Tick generator:** `divCnt` counts 0..DIV-1; `tick` asserts when `divCnt == DIV-1`. Within each bit, `smpCnt` (4-bit) increments on every tick and wraps 15→0, which marks a bit boundary.
- **Majority vote:** `rx` is captured on ticks with `smpCnt` = 7, 8 and 9. The bit value is the majority (≥2 of 3), decided on tick 9.
- **States:** IDLE, START, DATA, [PARITY], STOP, BREAK.
  - IDLE: on `rx` falling edge (previous 1, current 0), clear `divCnt`/`smpCnt` and go to START.
  - START: on tick 9, if the vote is 1 this is a false start; return to IDLE with no strobe. At the tick-15 boundary, go to DATA with `bitCnt` = 0.
  - DATA: on each tick 9, shift the vote into `shift[7]` (right shift, LSB first). At the boundary, `bitCnt`++. After bit 7's boundary, go to PARITY if compiled in, else STOP.
  - PARITY: on tick 9, store the vote. At the boundary, go to STOP.
  - STOP: on tick 9, if the vote is 1, load `o_data` ← `shift`, pulse `o_valid`, and go to IDLE immediately (no wait for the boundary). If the vote is 0, pulse `o_frameError`, leave `o_data` unchanged, and go to BREAK.
  - BREAK: stay until `rx` = 1, then go to IDLE. A held-low break produces exactly one `o_frameError`.
- **Strobe exclusivity:** `o_valid` and `o_frameError` never assert in the same cycle.
- **No backpressure:** the downstream FIFO must accept every `o_valid`; overflow is the FIFO's concern.

## Timing
- **Reset values:** `o_valid` = 0, `o_data` = 8'h00, `o_frameError` = 0, `o_parityError` = 0; state IDLE; synchroniser = 1; all counters 0.
- **Reset mid-frame:** the frame is aborted, no strobe is issued, and the next falling edge after release starts a new frame.
- **Sync latency:** 2 cycles from the pin to `rx`.
- **Strobe latency:** the falling edge of `rx` is cycle 0. The strobe occurs at cycle 0 + (9 bits × 16 + 10) × DIV + 1. With parity, add 16 × DIV. With the defaults this is 8317 cycles (no parity).
- **Back-to-back frames:** a start edge arriving ≥ 1 cycle after the STOP vote is accepted. Frames with no idle gap are received without loss.
- **Baud tolerance:** ±3 % total mismatch must decode correctly.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the frame is 8E1 or 8O1 according to `PARITY_ODD`, and the PARITY state is present.
  - On a good stop bit, `o_valid` pulses even on a parity mismatch. In that case `o_parityError` pulses in the same cycle as `o_valid`.
- **Undefined:** the frame is 8N1 and the PARITY state is removed. `o_parityError` is tied to 0; the port remains for instantiation compatibility.

## Test plan
All scenarios use defaults: DIV = 54, bit = 864 cycles.
- **Single byte:** drive 0xA5 (8N1) → exactly one `o_valid`, `o_data` = 0xA5, 8317 ± 1 cycles after the synchronised start edge; `o_frameError` = 0.
- **Glitch:** low pulse of 200 cycles on an idle line → no strobe; state returns to IDLE. A following 0x3C is then received correctly.
- **Framing:** send 0x55 with the stop bit low, then hold the line low for 3 bit times → one `o_frameError`, no `o_valid`, `o_data` keeps the previous value. Release, send 0x12 → `o_valid` with 0x12.
- **Throughput and tolerance:** 256 back-to-back bytes 0x00..0xFF, no idle gap, transmitter at 1.03× and at 0.97× baud → 256 `o_valid` pulses, data in order, no errors.
- **Reset mid-frame:** assert `i_resetn` = 0 for 2 cycles during DATA bit 4 of 0xFF → outputs take reset values, no strobe. The next byte, 0x81, is received correctly.
- **Parity (`UART_RX_PARITY_EN`, `PARITY_ODD` = 0):** 0x03 with parity bit 0 → `o_valid`, no `o_parityError`. 0x03 with parity bit 1 → `o_valid` and `o_parityError` in the same cycle.
